// File: rtl/uart_receiver.sv
// UART receiver: 5-8 data bits LSB-first, optional even parity, 1 or 2 stop bits.
// The line is oversampled at CLK_FREQ/BAUD_RATE clocks per bit and sampled at bit centres.
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  two_stop_bits,
  input  logic [1:0]            word_length,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  frame_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, CLEANUP, WAIT_HIGH
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [2:0]            bit_idx_reg, bit_idx_next;
  logic [7:0]            shift_reg, shift_next;
  logic                  par_acc_reg, par_acc_next;
  logic                  par_mis_reg, par_mis_next;
  logic                  par_en_reg, par_en_next;
  logic                  two_stop_reg, two_stop_next;
  logic [1:0]            wl_reg, wl_next;
  logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  parity_error_reg, parity_error_next;
  logic                  frame_error_reg, frame_error_next;
  logic                  rx_meta, rx_sync;
  logic                  bit_done;

  assign bit_done = (cnt_reg == BIT_LAST);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      bit_idx_reg      <= '0;
      shift_reg        <= '0;
      par_acc_reg      <= 1'b0;
      par_mis_reg      <= 1'b0;
      par_en_reg       <= 1'b0;
      two_stop_reg     <= 1'b0;
      wl_reg           <= '0;
      data_out_reg     <= '0;
      data_valid_reg   <= 1'b0;
      parity_error_reg <= 1'b0;
      frame_error_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      bit_idx_reg      <= bit_idx_next;
      shift_reg        <= shift_next;
      par_acc_reg      <= par_acc_next;
      par_mis_reg      <= par_mis_next;
      par_en_reg       <= par_en_next;
      two_stop_reg     <= two_stop_next;
      wl_reg           <= wl_next;
      data_out_reg     <= data_out_next;
      data_valid_reg   <= data_valid_next;
      parity_error_reg <= parity_error_next;
      frame_error_reg  <= frame_error_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = bit_done ? '0 : cnt_reg + 1'b1;
    bit_idx_next      = bit_idx_reg;
    shift_next        = shift_reg;
    par_acc_next      = par_acc_reg;
    par_mis_next      = par_mis_reg;
    par_en_next       = par_en_reg;
    two_stop_next     = two_stop_reg;
    wl_next           = wl_reg;
    data_out_next     = data_out_reg;
    data_valid_next   = 1'b0;
    parity_error_next = parity_error_reg;
    frame_error_next  = frame_error_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_sync) begin
          par_en_next       = parity_en;
          two_stop_next     = two_stop_bits;
          wl_next           = word_length;
          parity_error_next = 1'b0;
          frame_error_next  = 1'b0;
          bit_idx_next      = '0;
          shift_next        = '0;
          par_acc_next      = 1'b0;
          par_mis_next      = 1'b0;
          state_next        = START;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next[bit_idx_reg] = rx_sync;
          par_acc_next            = par_acc_reg ^ rx_sync;
          // Last index is word length minus one: 4 + word_length.
          if (bit_idx_reg == ({1'b0, wl_reg} + 3'd4)) begin
            state_next = par_en_reg ? PARITY : STOP1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_mis_next = rx_sync ^ par_acc_reg;
          state_next   = STOP1;
        end
      end
      STOP1, STOP2: begin
        if (bit_done) begin
          if (!rx_sync) begin
            frame_error_next = 1'b1;
            state_next       = WAIT_HIGH;
          end else if (state_reg == STOP1 && two_stop_reg) begin
            state_next = STOP2;
          end else begin
            state_next = CLEANUP;
          end
        end
      end
      CLEANUP: begin
        if (bit_done) begin
          data_out_next     = DATA_WIDTH'(shift_reg);
          parity_error_next = par_mis_reg;
          data_valid_next   = 1'b1;
          state_next        = IDLE;
        end
      end
      WAIT_HIGH: begin
        cnt_next = '0;
        if (rx_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_out     = data_out_reg;
  assign data_valid   = data_valid_reg;
  assign parity_error = parity_error_reg;
  assign frame_error  = frame_error_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed and random frames, scoreboard queue drained by a monitor.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       two_stop_bits = 1'b0;
  logic [1:0] word_length = 2'b11;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;

  uart_receiver #(.DATA_WIDTH(8), .CLK_FREQ(160), .BAUD_RATE(10)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .parity_en(parity_en),
    .two_stop_bits(two_stop_bits), .word_length(word_length),
    .data_out(data_out), .data_valid(data_valid),
    .parity_error(parity_error), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic perr; } exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  // Reference: frame contents follow directly from the word length and parity rules.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] wl, input logic pe,
                            input logic ts, input logic flip_par, input logic bad_stop);
    int n;
    logic [7:0] dm;
    logic par;
    n   = 5 + int'(wl);
    dm  = d & 8'((1 << n) - 1);
    par = (^dm) ^ flip_par;
    @(negedge clk);
    parity_en = pe; two_stop_bits = ts; word_length = wl;
    bits(1);
    rx = 1'b0;
    bits(1);
    parity_en = 1'($urandom); two_stop_bits = 1'($urandom); word_length = 2'($urandom);
    for (int i = 0; i < n; i++) begin
      rx = dm[i];
      bits(1);
    end
    if (pe) begin
      rx = par;
      bits(1);
    end
    rx = ~bad_stop;
    bits(1);
    if (ts && !bad_stop) bits(1);
    rx = 1'b1;
    if (!bad_stop) exp_q.push_back('{data: dm, perr: pe & flip_par});
    $display("frame data=%02h wl=%0d pe=%0b ts=%0b flip=%0b bad_stop=%0b", dm, wl, pe, ts, flip_par, bad_stop);
    bits(2);
  endtask

  // Monitor: every data_valid must match the oldest expected frame.
  always @(negedge clk) begin
    if (rstn && data_valid) begin
      if (prev_valid) chk("valid_width", 32'd2, 32'd1);
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.data));
        chk("parity_error", 32'(parity_error), 32'(e.perr));
        chk("frame_error_on_valid", 32'(frame_error), 32'd0);
        $display("rx word data_out=%02h parity_error=%0b", data_out, parity_error);
      end
    end
    prev_valid <= data_valid;
  end

  initial begin
    int wait_cnt;
    repeat (3) @(negedge clk);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_valid", 32'(data_valid), 32'd0);
    chk("reset_perr", 32'(parity_error), 32'd0);
    chk("reset_ferr", 32'(frame_error), 32'd0);
    rstn = 1'b1;
    bits(1);

    send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h41, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h43, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'hAA, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h12, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ferr_after_bad_stop", 32'(frame_error), 32'd1);
    chk("perr_after_bad_stop", 32'(parity_error), 32'd0);
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ferr_cleared", 32'(frame_error), 32'd0);

    // Short low glitch: false start, no word delivered.
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    bits(2);
    chk("glitch_ferr", 32'(frame_error), 32'd0);
    chk("glitch_data_hold", 32'(data_out), 32'h3C);

    // Reset in the middle of a frame aborts it.
    rx = 1'b0;
    bits(3);
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset_data_out", 32'(data_out), 32'd0);
    chk("midreset_ferr", 32'(frame_error), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    bits(2);

    for (int k = 0; k < 40; k++) begin
      logic pe;
      pe = 1'($urandom);
      send_frame(8'($urandom), 2'($urandom), pe, 1'($urandom),
                 pe & 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10 * CPB) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
